// File: rtl/bp_be_pkg.sv
// Shared types for the back-end branch resolver: FSM states and the registered FE command.
package bp_be_pkg;

   localparam int unsigned vaddr_width_gp = 39;

   typedef enum logic [0:0] {
      e_run,
      e_send
   } bp_be_br_res_state_e;

   typedef struct packed {
      logic                      redirect;
      logic                      btaken;
      logic [vaddr_width_gp-1:0] npc;
   } bp_be_fe_cmd_lite_s;

endpackage

// File: rtl/bp_be_branch_resolver_if.sv
// Branch packet in, FE command out; master drives the packet and ready, slave is the resolver.
interface bp_be_branch_resolver_if #(
   parameter int unsigned vaddr_width_p       = 39,
   parameter int unsigned mispred_cnt_width_p = 16
);

   logic                           br_v_i;
   logic                           br_branch_i;
   logic                           br_btaken_i;
   logic [vaddr_width_p-1:0]       br_npc_i;
   logic                           exp_npc_v_i;
   logic [vaddr_width_p-1:0]       exp_npc_i;
   logic                           fe_cmd_v_o;
   logic                           fe_cmd_ready_i;
   logic                           fe_cmd_redirect_o;
   logic [vaddr_width_p-1:0]       fe_cmd_npc_o;
   logic                           fe_cmd_btaken_o;
   logic                           flush_o;
   logic                           busy_o;
   logic [mispred_cnt_width_p-1:0] mispred_cnt_o;

   modport master (
      output br_v_i, br_branch_i, br_btaken_i, br_npc_i, exp_npc_v_i, exp_npc_i,
      output fe_cmd_ready_i,
      input  fe_cmd_v_o, fe_cmd_redirect_o, fe_cmd_npc_o, fe_cmd_btaken_o,
      input  flush_o, busy_o, mispred_cnt_o
   );

   modport slave (
      input  br_v_i, br_branch_i, br_btaken_i, br_npc_i, exp_npc_v_i, exp_npc_i,
      input  fe_cmd_ready_i,
      output fe_cmd_v_o, fe_cmd_redirect_o, fe_cmd_npc_o, fe_cmd_btaken_o,
      output flush_o, busy_o, mispred_cnt_o
   );

endinterface

// File: rtl/bp_be_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear on reset.
module bp_be_sat_counter #(
   parameter int unsigned width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);

   logic [width_p-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (inc_i && !(&count_q)) begin
         count_q <= count_q + width_p'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/bp_be_branch_resolver.sv
// Compares resolved next PC against the front-end prediction; redirects + flushes on mismatch,
// emits droppable attaboy training commands on correctly predicted branches.
module bp_be_branch_resolver
   import bp_be_pkg::*;
#(
   parameter int unsigned vaddr_width_p       = vaddr_width_gp,
   parameter int unsigned mispred_cnt_width_p = 16
) (
   input logic               clk_i,
   input logic               reset_i,
   bp_be_branch_resolver_if.slave br_if
);

   bp_be_br_res_state_e            state_q;
   bp_be_fe_cmd_lite_s             cmd_q;
   logic                           cmd_v_q;
   logic                           flush_q;
   logic [vaddr_width_p-1:0]       npc_aligned;
   logic                           accept;
   logic                           mispredict;
   logic                           mispred_inc;
   logic [mispred_cnt_width_p-1:0] mispred_cnt;

   // Targets are at least halfword aligned, so bit 0 never takes part in the compare.
   assign npc_aligned = br_if.br_npc_i & ~vaddr_width_p'(1);
   assign accept      = br_if.br_v_i && (state_q == e_run);
   assign mispredict  = !br_if.exp_npc_v_i || (npc_aligned != br_if.exp_npc_i);
   assign mispred_inc = accept && mispredict;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_run;
         cmd_q   <= '0;
         cmd_v_q <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         unique case (state_q)
            e_run: begin
               flush_q <= 1'b0;
               cmd_v_q <= 1'b0;
               // A redirect overrides any attaboy currently on the bus; an attaboy lives one cycle.
               if (accept && mispredict) begin
                  cmd_q   <= '{redirect: 1'b1, btaken: br_if.br_btaken_i, npc: npc_aligned};
                  cmd_v_q <= 1'b1;
                  flush_q <= 1'b1;
                  state_q <= e_send;
               end else if (accept && br_if.br_branch_i) begin
                  cmd_q   <= '{redirect: 1'b0, btaken: br_if.br_btaken_i, npc: npc_aligned};
                  cmd_v_q <= 1'b1;
               end
            end
            e_send: begin
               flush_q <= 1'b0;
               if (br_if.fe_cmd_ready_i) begin
                  cmd_v_q <= 1'b0;
                  state_q <= e_run;
               end
            end
            default: begin
               state_q <= e_run;
               cmd_v_q <= 1'b0;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   bp_be_sat_counter #(
      .width_p (mispred_cnt_width_p)
   ) u_mispred_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (mispred_inc),
      .count_o (mispred_cnt)
   );

   assign br_if.fe_cmd_v_o        = cmd_v_q;
   assign br_if.fe_cmd_redirect_o = cmd_q.redirect;
   assign br_if.fe_cmd_btaken_o   = cmd_q.btaken;
   assign br_if.fe_cmd_npc_o      = cmd_q.npc;
   assign br_if.flush_o           = flush_q;
   assign br_if.busy_o            = (state_q == e_send);
   assign br_if.mispred_cnt_o     = mispred_cnt;

endmodule

// File: tb/tb_bp_be_branch_resolver.sv
// Directed plus random stimulus against a transaction-level model of the branch resolver.
module tb_bp_be_branch_resolver;

   localparam int unsigned VA = 39;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          in_v, in_branch, in_btaken, in_expv, in_ready;
   logic [VA-1:0] in_npc, in_exp;

   bp_be_branch_resolver_if #(.vaddr_width_p(VA), .mispred_cnt_width_p(16)) if_a ();
   bp_be_branch_resolver_if #(.vaddr_width_p(VA), .mispred_cnt_width_p(2))  if_b ();

   assign if_a.br_v_i = in_v;         assign if_b.br_v_i = in_v;
   assign if_a.br_branch_i = in_branch; assign if_b.br_branch_i = in_branch;
   assign if_a.br_btaken_i = in_btaken; assign if_b.br_btaken_i = in_btaken;
   assign if_a.br_npc_i = in_npc;     assign if_b.br_npc_i = in_npc;
   assign if_a.exp_npc_v_i = in_expv; assign if_b.exp_npc_v_i = in_expv;
   assign if_a.exp_npc_i = in_exp;    assign if_b.exp_npc_i = in_exp;
   assign if_a.fe_cmd_ready_i = in_ready; assign if_b.fe_cmd_ready_i = in_ready;

   bp_be_branch_resolver #(.vaddr_width_p(VA), .mispred_cnt_width_p(16)) dut_a (
      .clk_i   (clk),
      .reset_i (rst),
      .br_if   (if_a)
   );

   bp_be_branch_resolver #(.vaddr_width_p(VA), .mispred_cnt_width_p(2)) dut_b (
      .clk_i   (clk),
      .reset_i (rst),
      .br_if   (if_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a redirect is either outstanding or not; what the FE sees next cycle follows from that.
   bit            m_pending, m_v, m_flush, m_redir, m_btaken, m_fields;
   logic [VA-1:0] m_npc;
   int            m_cnt, m_cnt_s;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input bit br, input bit tk, input logic [VA-1:0] npc,
                        input bit ev, input logic [VA-1:0] ex, input bit rdy);
      in_v = v; in_branch = br; in_btaken = tk; in_npc = npc;
      in_expv = ev; in_exp = ex; in_ready = rdy;
   endtask

   task automatic step(input string tag);
      logic [VA-1:0] tgt;
      bit            mis;
      tgt = in_npc;
      tgt[0] = 1'b0;
      if (rst) begin
         m_pending = 0; m_v = 0; m_flush = 0; m_redir = 0; m_btaken = 0; m_npc = '0;
         m_cnt = 0; m_cnt_s = 0; m_fields = 1;
      end else if (m_pending) begin
         m_flush = 0;
         if (in_ready) begin
            m_pending = 0; m_v = 0; m_fields = 0;
         end
      end else begin
         mis = in_v && (!in_expv || tgt != in_exp);
         m_flush = 0; m_v = 0; m_fields = 0;
         if (mis) begin
            m_pending = 1; m_v = 1; m_flush = 1; m_redir = 1;
            m_btaken = in_btaken; m_npc = tgt; m_fields = 1;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
         end else if (in_v && in_branch) begin
            m_v = 1; m_redir = 0; m_btaken = in_btaken; m_npc = tgt; m_fields = 1;
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".v"},     64'(if_a.fe_cmd_v_o), 64'(m_v));
      chk({tag, ".flush"}, 64'(if_a.flush_o),    64'(m_flush));
      chk({tag, ".busy"},  64'(if_a.busy_o),     64'(m_pending));
      chk({tag, ".cnt"},   64'(if_a.mispred_cnt_o), 64'(m_cnt));
      chk({tag, ".cnt2"},  64'(if_b.mispred_cnt_o), 64'(m_cnt_s));
      if (m_fields) begin
         chk({tag, ".redir"},  64'(if_a.fe_cmd_redirect_o), 64'(m_redir));
         chk({tag, ".btaken"}, 64'(if_a.fe_cmd_btaken_o),   64'(m_btaken));
         chk({tag, ".npc"},    64'(if_a.fe_cmd_npc_o),      64'(m_npc));
      end
   endtask

   initial begin
      int sat_exp [5];
      logic [VA-1:0] r_npc, r_exp;
      sat_exp = '{1, 2, 3, 3, 3};

      drive(0, 0, 0, '0, 0, '0, 0);
      rst = 1;
      step("reset");
      chk("reset_redir_zero", 64'(if_a.fe_cmd_redirect_o), 64'd0);
      rst = 0;

      // Correct taken branch -> attaboy
      drive(1, 1, 1, 39'h80000010, 1, 39'h80000010, 1);
      step("t1_n1");
      chk("t1_attaboy_npc", 64'(if_a.fe_cmd_npc_o), 64'h80000010);
      drive(0, 0, 0, '0, 0, '0, 1);
      step("t1_n2");

      // Mispredict, FE stalls three cycles; a second mispredict arrives during e_send
      drive(1, 1, 1, 39'h80000040, 1, 39'h80000004, 0);
      step("t2_n1");
      chk("t2_flush_n1", 64'(if_a.flush_o), 64'd1);
      drive(1, 1, 0, 39'h80000100, 1, 39'h80000008, 0);
      step("t3_n2");
      chk("t3_held_npc", 64'(if_a.fe_cmd_npc_o), 64'h80000040);
      drive(0, 0, 0, '0, 0, '0, 0);
      step("t2_n3");
      drive(0, 0, 0, '0, 0, '0, 1);
      step("t2_n4");
      chk("t2_cnt_one", 64'(if_a.mispred_cnt_o), 64'd1);
      step("t2_n5");

      // Attaboy dropped when FE is not ready
      drive(1, 1, 0, 39'h80000200, 1, 39'h80000200, 0);
      step("t4_n1");
      drive(0, 0, 0, '0, 0, '0, 0);
      step("t4_n2");
      chk("t4_busy_run", 64'(if_a.busy_o), 64'd0);

      // No expected PC on a non-branch -> redirect; reset while sending drops it
      drive(1, 0, 0, 39'h1000, 0, 39'h1000, 0);
      step("t5_n1");
      chk("t5_redir_npc", 64'(if_a.fe_cmd_npc_o), 64'h1000);
      drive(0, 0, 0, '0, 0, '0, 0);
      rst = 1;
      step("t5_rst");
      rst = 0;
      step("t5_after");

      // Saturation on the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 1, 39'h2000 + 39'(i * 16), 1, 39'h4, 1);
         step("t6_mis");
         chk("t6_sat_seq", 64'(if_b.mispred_cnt_o), 64'(sat_exp[i]));
         drive(0, 0, 0, '0, 0, '0, 1);
         step("t6_hs");
      end

      // Odd npc whose aligned value matches the prediction is a correct prediction
      drive(1, 1, 1, 39'h3001, 1, 39'h3000, 1);
      step("bit0_match");
      chk("bit0_attaboy", 64'(if_a.fe_cmd_redirect_o), 64'd0);

      for (int i = 0; i < 400; i++) begin
         r_npc = VA'({$urandom, $urandom});
         case ($urandom_range(0, 3))
            0:       r_exp = r_npc & ~VA'(1);
            1:       r_exp = r_npc | VA'(1);
            2:       r_exp = VA'({$urandom, $urandom});
            default: r_exp = (r_npc & ~VA'(1)) ^ (VA'(1) << $urandom_range(1, VA - 1));
         endcase
         drive(1'($urandom), 1'($urandom), 1'($urandom), r_npc,
               ($urandom_range(0, 7) != 0), r_exp, 1'($urandom));
         rst = ($urandom_range(0, 60) == 0);
         step("rand");
      end
      rst = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_be_branch_resolver.md
Name: bp_be_branch_resolver

Overview:
- Consumer end of the back-end branch packet interface.
- Each cycle, takes the resolved branch packet {v, branch, btaken, npc} from the control pipe and the front-end's expected next PC for that instruction.
- On a mismatch, issues a redirect command to the front-end command queue over valid/ready and pulses a flush to squash younger instructions.
- On correctly predicted branches, issues droppable "attaboy" training commands; keeps a saturating mispredict counter.

Parameters:
- vaddr_width_p, 39, virtual address width of npc/expected PC.
- mispred_cnt_width_p, 16, width of the saturating mispredict counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- br_v_i  in  1  packet valid (instruction retired through the control pipe, not poisoned).
- br_branch_i  in  1  instruction is a control-transfer op.
- br_btaken_i  in  1  branch resolved taken.
- br_npc_i  in  vaddr_width_p  resolved next PC.
- exp_npc_v_i  in  1  expected npc available for this packet.
- exp_npc_i  in  vaddr_width_p  front-end predicted next PC.
- fe_cmd_v_o  out  1  command valid.
- fe_cmd_ready_i  in  1  FE queue accepts command.
- fe_cmd_redirect_o  out  1  1 = redirect, 0 = attaboy.
- fe_cmd_npc_o  out  vaddr_width_p  target PC (bit 0 forced to 0).
- fe_cmd_btaken_o  out  1  taken flag for predictor training.
- flush_o  out  1  one-cycle squash of younger instructions.
- busy_o  out  1  redirect pending; upstream must stall issue.
- mispred_cnt_o  out  mispred_cnt_width_p  saturating mispredict count.

Behaviour:
- Reset: state e_run; all outputs 0, counter 0. Reset during e_send drops the pending redirect with no handshake.
- Packet classification, when br_v_i and state e_run:
  - mispredict = ~exp_npc_v_i | (br_npc_i != exp_npc_i).
  - Compare all vaddr_width_p bits; the compare uses br_npc_i with bit 0 cleared.
- Latency: packet in cycle N; flush_o, fe_cmd_v_o and the registered cmd fields are valid in N+1.
- States:
  - e_run: on a mispredicting packet, register npc/btaken, set flush_o=1 in N+1, increment the counter unless it is at all-ones, go to e_send.
  - e_run: on a correctly predicted packet with br_branch_i=1, register an attaboy and present fe_cmd_v_o for exactly one cycle (N+1). If fe_cmd_ready_i=0 in that cycle, drop the attaboy silently. Stay in e_run.
  - e_run: non-branch correct packets produce no output.
  - e_send: fe_cmd_v_o=1, fe_cmd_redirect_o=1, busy_o=1; fields held stable until fe_cmd_ready_i=1, then go to e_run next cycle.
  - e_send: any br_v_i is ignored; younger instructions are flushed.
  - flush_o is high only in the first cycle of e_send.
- Simultaneous events: a mispredict detected while an attaboy is being presented replaces it next cycle; the redirect always wins. A command handshake and a new packet in the same e_run cycle are both honoured.
- Counter saturates at 2^mispred_cnt_width_p - 1 with no wrap.
- Packets with br_v_i=0 have no effect regardless of other inputs.

Decomposition:
- bp_be_pkg: enum bp_be_br_res_state_e {e_run, e_send}.
- bp_be_pkg: bp_be_fe_cmd_lite_s {redirect, btaken, npc}, used for the registered command.
- Sub-module bp_be_sat_counter (parameterised width, inc_i, clear on reset): used for mispred_cnt_o.

Test Plan:
1. Correct taken branch: br_v=1, branch=1, btaken=1, npc=0x80000010, exp=0x80000010, ready=1 -> cycle N+1 fe_cmd_v_o=1, redirect=0, npc=0x80000010; flush_o=0; counter stays 0.
2. Mispredict with ready=0 for 3 cycles: npc=0x80000040, exp=0x80000004 -> flush_o=1 only in N+1; fe_cmd_v_o/redirect held with npc=0x80000040 through cycle N+4 handshake; busy_o=1 until handshake; counter=1.
3. Packet arriving while in e_send: second mispredict packet at N+2 -> no effect on held command or counter (counter stays 1).
4. Attaboy with ready=0: correct branch packet -> fe_cmd_v_o=1 only in N+1, then 0; state stays e_run.
5. exp_npc_v_i=0 with a non-branch packet, npc=0x1000 -> redirect to 0x1000 and flush; then reset asserted in e_send -> next cycle all outputs 0, state e_run.
6. Saturation: width 2, five mispredicts -> mispred_cnt_o reads 1, 2, 3, 3, 3.
